// File: rtl/trojan_param_leak.sv
// ============================================================================
// Module   : trojan_param_leak
// Brief    : Trigger-and-leak benchmark block. It watches a data word for a
//            magic pattern, captures WORDS chunks from a selected lane, then
//            shifts them out on a leak port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module trojan_param_leak #(
    parameter int                DATA_W   = 64,
    parameter int                TRIG_W   = 48,
    parameter logic [TRIG_W-1:0] TRIG_VAL = 48'h00000044ab93,
    parameter int                BITLEAK  = 2,
    parameter int                SEL_W    = 5,
    parameter int                WORDS    = 4,
    parameter bit                REARM    = 1'b0
) (
    input  logic               clk,
    input  logic               rst_all,
    input  logic [DATA_W-1:0]  data,
    output logic [BITLEAK-1:0] out,
    output logic               leak_valid,
    output logic               busy
);

    localparam int LANES      = DATA_W / BITLEAK;
    localparam int LANE_IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int K_W        = WORDS * BITLEAK;
    localparam int CNT_W      = $clog2(WORDS) + 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CAPTURE = 3'd1,
        LEAK    = 3'd2,
        DONE    = 3'd3,
        LOCKED  = 3'd4
    } state_t;

    state_t                  state;
    logic [LANE_IDX_W-1:0]   sel;
    logic [CNT_W-1:0]        cnt;
    logic [K_W-1:0]          k;

    logic [BITLEAK-1:0]      lanes [LANES];
    logic [BITLEAK-1:0]      lane;
    logic [SEL_W-1:0]        sel_field;
    logic                    trig;
    logic                    last;
    logic [K_W-1:0]          k_cap;
    logic [K_W-1:0]          k_shift;

    generate
        for (genvar i = 0; i < LANES; i++) begin : g_lane
            assign lanes[i] = data[i*BITLEAK +: BITLEAK];
        end
    endgenerate

    assign lane      = lanes[sel];
    assign sel_field = data[TRIG_W +: SEL_W];
    assign trig      = (data[TRIG_W-1:0] == TRIG_VAL);
    assign last      = (cnt == CNT_W'(WORDS - 1));
    assign k_shift   = k >> BITLEAK;

    // Place the current lane chunk into slot cnt using constant slices only.
    always_comb begin
        k_cap = k;
        for (int w = 0; w < WORDS; w++) begin
            if (cnt == CNT_W'(w)) begin
                k_cap[w*BITLEAK +: BITLEAK] = lane;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_all) begin
            state      <= IDLE;
            sel        <= '0;
            cnt        <= '0;
            k          <= '0;
            out        <= '0;
            leak_valid <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    out        <= '0;
                    leak_valid <= 1'b0;
                    if (trig) begin
                        // Out-of-range lane requests fall back to lane 0.
                        sel   <= (32'(sel_field) >= LANES) ? '0 : LANE_IDX_W'(sel_field);
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    k <= k_cap;
                    if (last) begin
                        cnt        <= '0;
                        out        <= k_cap[BITLEAK-1:0];
                        leak_valid <= 1'b1;
                        state      <= LEAK;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                LEAK: begin
                    if (last) begin
                        cnt        <= '0;
                        k          <= '0;
                        out        <= '0;
                        leak_valid <= 1'b0;
                        state      <= DONE;
                    end else begin
                        k   <= k_shift;
                        cnt <= cnt + CNT_W'(1);
                        out <= k_shift[BITLEAK-1:0];
                    end
                end
                DONE: begin
                    k          <= '0;
                    out        <= '0;
                    leak_valid <= 1'b0;
                    busy       <= 1'b0;
                    state      <= REARM ? IDLE : LOCKED;
                end
                LOCKED: begin
                    out        <= '0;
                    leak_valid <= 1'b0;
                    busy       <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_trojan_param_leak.sv
// ============================================================================
// Module   : tb_trojan_param_leak
// Brief    : Bench for trojan_param_leak in three configurations against a
//            timeline-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_trojan_param_leak;

    localparam logic [47:0] TRIG = 48'h00000044ab93;

    logic        clk;
    logic        rst0, rst1, rst2;
    logic [63:0] data0, data1, data2;
    logic [1:0]  out0, out1;
    logic [3:0]  out2;
    logic        lv0, lv1, lv2;
    logic        busy0, busy1, busy2;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Model state per instance: trigger edge, activation history, lane, chunks.
    int          m_t    [3];
    bit          m_had  [3];
    int          m_sel  [3];
    logic [3:0]  m_ch   [3][8];
    logic [3:0]  m_out  [3];
    bit          m_lv   [3];
    bit          m_busy [3];

    trojan_param_leak u0 (
        .clk(clk), .rst_all(rst0), .data(data0),
        .out(out0), .leak_valid(lv0), .busy(busy0)
    );

    trojan_param_leak #(.REARM(1'b1)) u1 (
        .clk(clk), .rst_all(rst1), .data(data1),
        .out(out1), .leak_valid(lv1), .busy(busy1)
    );

    trojan_param_leak #(.BITLEAK(4), .WORDS(8), .REARM(1'b1)) u2 (
        .clk(clk), .rst_all(rst2), .data(data2),
        .out(out2), .leak_valid(lv2), .busy(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] rand_word();
        logic [63:0] w;
        w = {$urandom, $urandom};
        if (w[47:0] == TRIG) w[0] = ~w[0];
        return w;
    endfunction

    function automatic logic [63:0] trig_word(input int s);
        logic [63:0] w;
        w = rand_word();
        w[47:0]  = TRIG;
        w[52:48] = 5'(s);
        return w;
    endfunction

    // Outcome after the edge numbered cyc, from the trigger timeline.
    task automatic model_step(input int id, input int w, input int b, input bit rearm,
                              input bit rst, input logic [63:0] d);
        int k, lanes, sf;
        lanes = 64 / b;
        if (rst) begin
            m_t[id]   = -1000;
            m_had[id] = 1'b0;
        end else begin
            k = cyc - m_t[id];
            if (k > 2*w + 1) begin
                if (d[47:0] == TRIG && !(m_had[id] && !rearm)) begin
                    sf         = int'(d[52:48]);
                    m_sel[id]  = (sf >= lanes) ? 0 : sf;
                    m_t[id]    = cyc;
                    m_had[id]  = 1'b1;
                end
            end else if (k >= 1 && k <= w) begin
                m_ch[id][k-1] = 4'((d >> (m_sel[id] * b)) & ((64'd1 << b) - 64'd1));
            end
        end
        k = cyc - m_t[id];
        m_lv[id]   = (k >= w && k < 2*w);
        m_out[id]  = m_lv[id] ? m_ch[id][k-w] : 4'd0;
        m_busy[id] = (k >= 0 && k <= 2*w);
    endtask

    task automatic tick();
        cyc++;
        model_step(0, 4, 2, 1'b0, rst0, data0);
        model_step(1, 4, 2, 1'b1, rst1, data1);
        model_step(2, 8, 4, 1'b1, rst2, data2);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
        data0 = trig_word(3); data1 = trig_word(0); data2 = trig_word(20);
        tick();
        tick();
        total++;
        if ({out0, lv0, busy0} !== 4'b0) begin
            bad++; $display("FAIL reset_u0 got=%b exp=0000", {out0, lv0, busy0});
        end
        total++;
        if ({out1, lv1, busy1} !== 4'b0) begin
            bad++; $display("FAIL reset_u1 got=%b exp=0000", {out1, lv1, busy1});
        end
        total++;
        if ({out2, lv2, busy2} !== 6'b0) begin
            bad++; $display("FAIL reset_u2 got=%b exp=000000", {out2, lv2, busy2});
        end
        rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
        data0 = '0; data1 = '0; data2 = '0;
        tick();
    endtask

    task automatic test_basic();
        logic [1:0] pat [4];
        logic [7:0] seq;
        int nlv;
        pat = '{2'b01, 2'b10, 2'b11, 2'b00};
        seq = '0;
        nlv = 0;
        for (int i = 0; i < 14; i++) begin
            if (i == 0) data0 = 64'h0003_0000_0044_ab93;
            else begin
                data0 = rand_word();
                if (i <= 4) data0[7:6] = pat[i-1];
            end
            tick();
            total++;
            if ({2'b00, out0} !== m_out[0] || lv0 !== m_lv[0] || busy0 !== m_busy[0]) begin
                bad++;
                $display("FAIL basic cyc=%0d out/lv/busy got=%h/%b/%b exp=%h/%b/%b",
                         cyc, out0, lv0, busy0, m_out[0], m_lv[0], m_busy[0]);
            end
            if (lv0) begin seq = {seq[5:0], out0}; nlv++; end
        end
        total++;
        if (seq !== 8'b01101100 || nlv != 4 || busy0 !== 1'b0) begin
            bad++;
            $display("FAIL basic_seq got=%b/%0d/%b exp=01101100/4/0", seq, nlv, busy0);
        end
    endtask

    task automatic test_lockout();
        int nlv;
        nlv = 0;
        for (int i = 0; i < 14; i++) begin
            data0 = (i == 0 || i == 5) ? trig_word(5) : rand_word();
            tick();
            total++;
            if ({2'b00, out0} !== m_out[0] || lv0 !== m_lv[0] || busy0 !== m_busy[0]) begin
                bad++;
                $display("FAIL locked cyc=%0d out/lv/busy got=%h/%b/%b exp=%h/%b/%b",
                         cyc, out0, lv0, busy0, m_out[0], m_lv[0], m_busy[0]);
            end
            if (lv0 || busy0) nlv++;
        end
        total++;
        if (nlv != 0) begin
            bad++; $display("FAIL locked_count got=%0d exp=0", nlv);
        end
        rst0 = 1'b1; data0 = rand_word();
        tick();
        rst0 = 1'b0;
        for (int i = 0; i < 14; i++) begin
            data0 = (i == 0) ? trig_word(int'($urandom_range(0, 31))) : rand_word();
            tick();
            total++;
            if ({2'b00, out0} !== m_out[0] || lv0 !== m_lv[0] || busy0 !== m_busy[0]) begin
                bad++;
                $display("FAIL relock cyc=%0d out/lv/busy got=%h/%b/%b exp=%h/%b/%b",
                         cyc, out0, lv0, busy0, m_out[0], m_lv[0], m_busy[0]);
            end
            if (lv0) nlv++;
        end
        total++;
        if (nlv != 4) begin
            bad++; $display("FAIL after_rst_leaks got=%0d exp=4", nlv);
        end
    endtask

    task automatic test_retrigger();
        int nlv;
        nlv = 0;
        rst0 = 1'b1; tick(); rst0 = 1'b0;
        for (int i = 0; i < 24; i++) begin
            data0 = (i < 12) ? trig_word(int'($urandom_range(0, 31))) : rand_word();
            tick();
            total++;
            if ({2'b00, out0} !== m_out[0] || lv0 !== m_lv[0] || busy0 !== m_busy[0]) begin
                bad++;
                $display("FAIL retrig cyc=%0d out/lv/busy got=%h/%b/%b exp=%h/%b/%b",
                         cyc, out0, lv0, busy0, m_out[0], m_lv[0], m_busy[0]);
            end
            if (lv0) nlv++;
        end
        total++;
        if (nlv != 4) begin
            bad++; $display("FAIL retrig_count got=%0d exp=4", nlv);
        end
    endtask

    task automatic test_reset_mid();
        int nbusy;
        nbusy = 0;
        rst0 = 1'b1; tick(); rst0 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            data0 = (i == 0) ? trig_word(9) : rand_word();
            rst0  = (i == 6);
            tick();
        end
        total++;
        if ({out0, lv0, busy0} !== 4'b0) begin
            bad++; $display("FAIL mid_leak_rst got=%b exp=0000", {out0, lv0, busy0});
        end
        rst0 = 1'b1; data0 = trig_word(2);
        tick();
        rst0 = 1'b0;
        for (int i = 0; i < 12; i++) begin
            data0 = rand_word();
            tick();
            total++;
            if ({2'b00, out0} !== m_out[0] || lv0 !== m_lv[0] || busy0 !== m_busy[0]) begin
                bad++;
                $display("FAIL rst_trig cyc=%0d out/lv/busy got=%h/%b/%b exp=%h/%b/%b",
                         cyc, out0, lv0, busy0, m_out[0], m_lv[0], m_busy[0]);
            end
            if (busy0 || lv0) nbusy++;
        end
        total++;
        if (nbusy != 0) begin
            bad++; $display("FAIL rst_trig_active got=%0d exp=0", nbusy);
        end
    endtask

    task automatic test_rearm();
        int nlv;
        nlv = 0;
        for (int i = 0; i < 40; i++) begin
            if (i == 0)       data1 = trig_word(0);
            else if (i == 20) data1 = trig_word(31);
            else              data1 = rand_word();
            tick();
            total++;
            if ({2'b00, out1} !== m_out[1] || lv1 !== m_lv[1] || busy1 !== m_busy[1]) begin
                bad++;
                $display("FAIL rearm cyc=%0d out/lv/busy got=%h/%b/%b exp=%h/%b/%b",
                         cyc, out1, lv1, busy1, m_out[1], m_lv[1], m_busy[1]);
            end
            if (lv1) nlv++;
        end
        total++;
        if (nlv != 8) begin
            bad++; $display("FAIL rearm_count got=%0d exp=8", nlv);
        end
    endtask

    task automatic test_wide();
        logic [3:0] q[$];
        logic [3:0] e;
        int nlv;
        nlv = 0;
        for (int i = 0; i < 22; i++) begin
            data2 = (i == 0) ? trig_word(20) : rand_word();
            if (i >= 1 && i <= 8) q.push_back(data2[3:0]);
            tick();
            total++;
            if (out2 !== m_out[2] || lv2 !== m_lv[2] || busy2 !== m_busy[2]) begin
                bad++;
                $display("FAIL wide cyc=%0d out/lv/busy got=%h/%b/%b exp=%h/%b/%b",
                         cyc, out2, lv2, busy2, m_out[2], m_lv[2], m_busy[2]);
            end
            if (lv2) begin
                nlv++;
                e = (q.size() > 0) ? q.pop_front() : 4'hx;
                total++;
                if (out2 !== e) begin
                    bad++; $display("FAIL wide_lane0 cyc=%0d got=%h exp=%h", cyc, out2, e);
                end
            end
        end
        total++;
        if (nlv != 8) begin
            bad++; $display("FAIL wide_count got=%0d exp=8", nlv);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            data0 = ($urandom_range(0, 5) == 0) ? trig_word(int'($urandom_range(0, 31))) : rand_word();
            data1 = ($urandom_range(0, 5) == 0) ? trig_word(int'($urandom_range(0, 31))) : rand_word();
            data2 = ($urandom_range(0, 5) == 0) ? trig_word(int'($urandom_range(0, 31))) : rand_word();
            rst0  = ($urandom_range(0, 59) == 0);
            rst1  = ($urandom_range(0, 59) == 0);
            rst2  = ($urandom_range(0, 59) == 0);
            tick();
            total++;
            if ({2'b00, out0} !== m_out[0] || lv0 !== m_lv[0] || busy0 !== m_busy[0] ||
                {2'b00, out1} !== m_out[1] || lv1 !== m_lv[1] || busy1 !== m_busy[1] ||
                out2 !== m_out[2] || lv2 !== m_lv[2] || busy2 !== m_busy[2]) begin
                bad++;
                $display("FAIL random cyc=%0d got=%h%b%b/%h%b%b/%h%b%b exp=%h%b%b/%h%b%b/%h%b%b",
                         cyc, out0, lv0, busy0, out1, lv1, busy1, out2, lv2, busy2,
                         m_out[0], m_lv[0], m_busy[0], m_out[1], m_lv[1], m_busy[1],
                         m_out[2], m_lv[2], m_busy[2]);
            end
        end
        rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
    endtask

    initial begin
        rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
        data0 = '0; data1 = '0; data2 = '0;
        for (int i = 0; i < 3; i++) begin
            m_t[i] = -1000; m_had[i] = 1'b0; m_sel[i] = 0;
            m_out[i] = '0; m_lv[i] = 1'b0; m_busy[i] = 1'b0;
            for (int j = 0; j < 8; j++) m_ch[i][j] = '0;
        end
        @(negedge clk);
        test_reset();
        test_basic();
        test_lockout();
        test_retrigger();
        test_reset_mid();
        test_rearm();
        test_wide();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
